node_fetch_engine: RTL
======================

NODE_FETCH_ENGINE -- requirements
Module: node_fetch_engine

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, max beats per AXI read burst (power of 2, 1..256).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse launching a fetch job.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH, byte address of first node word, 4-byte aligned.
REQ-007 SHALL have port total_nodes, input, 16, 32-bit words to fetch.
REQ-008 SHALL have port fetch_req, input, 1, downstream buffer requests more data.
REQ-009 SHALL have port fetch_grant, output, 1, one-cycle pulse when a burst is accepted on AR.
REQ-010 SHALL have ports out_data (output, 32), out_valid (output, 1), out_ready (input, 1), downstream word stream.
REQ-011 SHALL have ports m_araddr (output, ADDR_WIDTH), m_arlen (output, 8), m_arsize (output, 3), m_arburst (output, 2), m_arvalid (output, 1), m_arready (input, 1).
REQ-012 SHALL have ports m_rdata (input, 32), m_rresp (input, 2), m_rlast (input, 1), m_rvalid (input, 1), m_rready (output, 1).
REQ-013 SHALL have ports busy (output, 1), done (output, 1), rd_error (output, 1).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, ADDR, DATA, FIN.
REQ-015 IDLE: on start, latch base_addr and total_nodes, clear rd_error, go REQ; if total_nodes==0 go FIN directly.
REQ-016 REQ: when fetch_req==1 and remaining>0, compute beats = min(BURST_LEN, remaining, boundary limit per REQ-027), go ADDR.
REQ-017 ADDR: m_arvalid=1, m_araddr=current addr, m_arlen=beats-1, m_arsize=3'b010, m_arburst=2'b01; m_arvalid and fields SHALL hold stable until m_arready.
REQ-018 On AR handshake: fetch_grant pulses 1 cycle, addr += 4*beats, remaining -= beats, go DATA.
REQ-019 At most one burst outstanding; next AR SHALL NOT issue before last beat of current burst accepted.
REQ-020 DATA: m_rready = out_ready; out_valid = m_rvalid; out_data = m_rdata; zero added latency (combinational pass-through).
REQ-021 Beat on m_rvalid&&m_rready; after beat with m_rlast=1: go REQ if remaining>0, else FIN.
REQ-022 Any beat with m_rresp!=0 SHALL set rd_error (sticky until next start); beat still forwarded.
REQ-023 FIN: done pulses 1 cycle, return IDLE.
REQ-024 busy=1 in every state except IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 Outside DATA: m_rready=0, out_valid=0; outside ADDR: m_arvalid=0.

Reset
REQ-027 (see Configuration for boundary limit.) On rst_n low, FSM->IDLE asynchronously; m_arvalid, m_rready, out_valid, fetch_grant, busy, done, rd_error =0; m_araddr, m_arlen, out_data =0.
REQ-028 Reset mid-burst SHALL abandon the job; no resumption after release.

Configuration
REQ-029 Macro NODE_FETCH_4K_GUARD_EN defined: beats also limited to (4096 - addr[11:0])/4 so no burst crosses a 4 KB boundary.
REQ-030 Macro undefined: no boundary limit; bursts are min(BURST_LEN, remaining); caller guarantees boundary safety.

Verification
REQ-031 base=0x1000, total=40, BURST_LEN=16, fetch_req=1, zero-wait slave -> ARs at 0x1000/0x1040/0x1080 with arlen 15/15/7, 40 words in order, done once.
REQ-032 guard defined, base=0x0FF0, total=16 -> ARs 0x0FF0 arlen 3, then 0x1000 arlen 11; guard undefined -> single AR 0x0FF0 arlen 15.
REQ-033 out_ready toggled 1-0 each cycle, total=16 -> m_rready mirrors out_ready, no word lost/duplicated, 16 words delivered.
REQ-034 fetch_req=0 after first grant, total=32 -> second AR withheld until fetch_req=1; m_arvalid held with arready=0 -> araddr/arlen stable.
REQ-035 beat 5 with rresp=2'b10 -> rd_error=1 through done, cleared on next start; total=0 -> done one cycle after start, no AR.
REQ-036 rst_n low during DATA beat 3 -> all outputs 0 immediately, IDLE; new start after release runs clean job.

Source files
------------

// File: rtl/node_fetch_engine.sv
// node_fetch_engine: AXI4 read-burst engine streaming 32-bit node words.
// Define NODE_FETCH_4K_GUARD_EN to keep each burst inside a 4 KB page.
module node_fetch_engine #(
  parameter int BURST_LEN  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           total_nodes,
  input  logic                  fetch_req,
  output logic                  fetch_grant,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           rem_q, rem_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;

  logic [16:0] beats;
  logic [8:0]  len_beats;
  logic        in_data;
  logic        r_hs;
`ifdef NODE_FETCH_4K_GUARD_EN
  logic [16:0] page_left;
`endif

  assign len_beats = {1'b0, len_q} + 9'd1;
  assign in_data   = (state_q == S_DATA);
  assign r_hs      = in_data && m_rvalid && out_ready;

  // Size of the next burst: burst cap, words left, and page room.
  always_comb begin
    beats = (17'(BURST_LEN) < {1'b0, rem_q}) ?
            17'(BURST_LEN) : {1'b0, rem_q};
`ifdef NODE_FETCH_4K_GUARD_EN
    page_left = 17'((13'd4096 - {1'b0, addr_q[11:0]}) >> 2);
    if (page_left < beats) beats = page_left;
`endif
  end

  // Job sequencing: one AR, then its data, then decide again.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = total_nodes;
          err_d   = 1'b0;
          state_d = (total_nodes == 16'd0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (fetch_req && rem_q != 16'd0) begin
          len_d   = 8'(beats - 17'd1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_arready) begin
          addr_d  = addr_q + ADDR_WIDTH'({len_beats, 2'b00});
          rem_d   = rem_q - 16'(len_beats);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          if (m_rresp != 2'b00) err_d = 1'b1;
          if (m_rlast) begin
            state_d = (rem_q != 16'd0) ? S_REQ : S_FIN;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign m_arvalid   = (state_q == S_ADDR);
  assign m_araddr    = addr_q;
  assign m_arlen     = len_q;
  assign m_arsize    = 3'b010;
  assign m_arburst   = 2'b01;
  assign fetch_grant = m_arvalid && m_arready;

  assign m_rready  = in_data && out_ready;
  assign out_valid = in_data && m_rvalid;
  assign out_data  = in_data ? m_rdata : 32'd0;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign rd_error = err_q;

endmodule
